// File: rtl/spi_slave_port_pkg.sv
// Shared types and SPI mode constants for the mode-0 SPI slave port.
package spi_slave_port_pkg;

    typedef enum logic {
        IDLE,
        ACTIVE
    } state_t;

    localparam logic SPI_CPOL  = 1'b0;
    localparam logic SPI_CPHA  = 1'b0;
    localparam int   DEF_WIDTH = 8;

endpackage

// File: rtl/spi_slave_port_if.sv
// Client-side word handshake and status bundle of the SPI slave port.
interface spi_slave_port_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] tx_data;
    logic             tx_valid;
    logic             tx_ready;
    logic [WIDTH-1:0] rx_data;
    logic             rx_valid;
    logic             rx_ready;
    logic             rx_overrun;
    logic             tx_underrun;
    logic             frame_err;
    logic             busy;

    modport slave (
        input  tx_data, tx_valid, rx_ready,
        output tx_ready, rx_data, rx_valid,
        output rx_overrun, tx_underrun, frame_err, busy
    );

    modport master (
        output tx_data, tx_valid, rx_ready,
        input  tx_ready, rx_data, rx_valid,
        input  rx_overrun, tx_underrun, frame_err, busy
    );
endinterface

// File: rtl/spi_slave_port_sync_edge.sv
// Multi-flop synchroniser with one delayed flop for edge detection.
module spi_slave_port_sync_edge #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic level,
    output logic rise,
    output logic fall
);
    logic [STAGES-1:0] sync_q;
    logic              dly_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= {STAGES{RST_VAL}};
            dly_q  <= RST_VAL;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
            dly_q  <= sync_q[STAGES-1];
        end
    end

    assign level = sync_q[STAGES-1];
    assign rise  = level & ~dly_q;
    assign fall  = ~level & dly_q;
endmodule

// File: rtl/spi_slave_port.sv
// Mode-0 SPI slave: oversampled sck/mosi/ss_n, word RX/TX with
// one-entry TX buffer and single-word RX holding register.
module spi_slave_port
    import spi_slave_port_pkg::*;
#(
    parameter int               WIDTH       = DEF_WIDTH,
    parameter int               SYNC_STAGES = 2,
    parameter logic [WIDTH-1:0] TX_DEFAULT  = '0
) (
    input  logic clk,
    input  logic rst,
    input  logic ss_n,
    input  logic sck,
    input  logic mosi,
    output logic miso,
    spi_slave_port_if.slave bus
);
    localparam int   CW      = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic ON_RISE = (SPI_CPOL == SPI_CPHA);

    logic sel_rise, sel_fall, sck_rise, sck_fall, mosi_s;
    logic unused_sel_lvl, unused_sck_lvl;
    logic unused_mosi_rise, unused_mosi_fall;

    spi_slave_port_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ss (
        .clk(clk), .rst(rst), .d(ss_n),
        .level(unused_sel_lvl), .rise(sel_rise), .fall(sel_fall)
    );

    spi_slave_port_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(SPI_CPOL)) u_sck (
        .clk(clk), .rst(rst), .d(sck),
        .level(unused_sck_lvl), .rise(sck_rise), .fall(sck_fall)
    );

    spi_slave_port_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi (
        .clk(clk), .rst(rst), .d(mosi),
        .level(mosi_s), .rise(unused_mosi_rise), .fall(unused_mosi_fall)
    );

    state_t           state;
    logic [CW-1:0]    bit_cnt;
    logic [WIDTH-1:0] rx_shift, tx_shift, tx_buf, rx_data;
    logic             tx_full, rx_valid, word_done;
    logic             rx_overrun, tx_underrun, frame_err;

    logic             sample_edge, shift_edge, last_bit, word_start;
    logic [WIDTH-1:0] rx_next;
    logic             unused_rx_msb;

    assign sample_edge   = ON_RISE ? sck_rise : sck_fall;
    assign shift_edge    = ON_RISE ? sck_fall : sck_rise;
    assign last_bit      = (bit_cnt == CW'(WIDTH - 1));
    assign rx_next       = {rx_shift[WIDTH-2:0], mosi_s};
    assign unused_rx_msb = rx_shift[WIDTH-1];

    // A word starts on selection or on the first shift edge after completion.
    assign word_start = (state == IDLE && sel_fall) ||
                        (state == ACTIVE && !sel_rise && shift_edge && word_done);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            rx_shift    <= '0;
            tx_shift    <= '0;
            tx_buf      <= '0;
            tx_full     <= 1'b0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            word_done   <= 1'b0;
            miso        <= 1'b0;
            rx_overrun  <= 1'b0;
            tx_underrun <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            rx_overrun  <= 1'b0;
            tx_underrun <= 1'b0;
            frame_err   <= 1'b0;

            if (rx_valid && bus.rx_ready)
                rx_valid <= 1'b0;

            if (bus.tx_valid && !tx_full) begin
                tx_buf  <= bus.tx_data;
                tx_full <= 1'b1;
            end

            if (word_start) begin
                if (tx_full) begin
                    tx_shift <= tx_buf;
                    miso     <= tx_buf[WIDTH-1];
                    tx_full  <= 1'b0;
                end else begin
                    tx_shift    <= TX_DEFAULT;
                    miso        <= TX_DEFAULT[WIDTH-1];
                    tx_underrun <= 1'b1;
                end
            end

            unique case (state)
                IDLE: begin
                    if (sel_fall) begin
                        state     <= ACTIVE;
                        bit_cnt   <= '0;
                        word_done <= 1'b0;
                    end
                end
                ACTIVE: begin
                    if (sel_rise) begin
                        state     <= IDLE;
                        miso      <= 1'b0;
                        bit_cnt   <= '0;
                        rx_shift  <= '0;
                        word_done <= 1'b0;
                        frame_err <= (bit_cnt != '0);
                    end else begin
                        if (sample_edge) begin
                            rx_shift <= rx_next;
                            if (last_bit) begin
                                bit_cnt    <= '0;
                                rx_data    <= rx_next;
                                rx_valid   <= 1'b1;
                                word_done  <= 1'b1;
                                rx_overrun <= rx_valid && !bus.rx_ready;
                            end else begin
                                bit_cnt <= bit_cnt + CW'(1);
                            end
                        end
                        if (shift_edge) begin
                            if (word_done) begin
                                word_done <= 1'b0;
                            end else begin
                                tx_shift <= tx_shift << 1;
                                miso     <= tx_shift[WIDTH-2];
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.tx_ready    = !tx_full;
    assign bus.rx_data     = rx_data;
    assign bus.rx_valid    = rx_valid;
    assign bus.rx_overrun  = rx_overrun;
    assign bus.tx_underrun = tx_underrun;
    assign bus.frame_err   = frame_err;
    assign bus.busy        = (state == ACTIVE);
endmodule

// File: tb/tb_spi_slave_port.sv
// Directed bench for spi_slave_port with MISO and RX scoreboards.
module tb_spi_slave_port;
    localparam int          HALF = 8;
    localparam logic [7:0]  TXD  = 8'hC6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ss_n = 1'b1;
    logic sck = 1'b0;
    logic mosi = 1'b0;
    logic miso;

    spi_slave_port_if #(.WIDTH(8)) bus ();

    spi_slave_port #(
        .WIDTH(8), .SYNC_STAGES(2), .TX_DEFAULT(TXD)
    ) dut (
        .clk(clk), .rst(rst), .ss_n(ss_n), .sck(sck),
        .mosi(mosi), .miso(miso), .bus(bus)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;
    int n_under = 0;
    int n_over = 0;
    int n_ferr = 0;
    logic       miso_q[$];
    logic [7:0] rx_q[$];
    logic [7:0] got_q[$];

    always @(posedge clk) begin
        if (!rst) begin
            if (bus.tx_underrun) n_under++;
            if (bus.rx_overrun) n_over++;
            if (bus.frame_err) n_ferr++;
            if (bus.rx_valid && bus.rx_ready) got_q.push_back(bus.rx_data);
        end
    end

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    endtask

    task automatic cycles(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_tx(logic [7:0] d);
        int k = 0;
        while (!bus.tx_ready && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (!bus.tx_ready) check("tx_ready_timeout", 0, 1);
        bus.tx_data  = d;
        bus.tx_valid = 1'b1;
        @(negedge clk);
        bus.tx_valid = 1'b0;
    endtask

    task automatic select();
        ss_n = 1'b0;
        cycles(HALF);
    endtask

    task automatic deselect();
        cycles(HALF);
        ss_n = 1'b1;
        cycles(2 * HALF);
    endtask

    task automatic xfer(string tag, logic [7:0] mo, logic [7:0] exp, int nb);
        logic [7:0] e;
        for (int i = 0; i < nb; i++) miso_q.push_back(exp[7-i]);
        for (int i = 0; i < nb; i++) begin
            mosi = mo[7-i];
            cycles(HALF);
            e = {7'd0, miso_q.pop_front()};
            check($sformatf("%s_miso%0d", tag, i), {31'd0, miso}, {24'd0, e});
            sck = 1'b1;
            cycles(HALF);
            sck = 1'b0;
        end
    endtask

    task automatic chk_rx(string tag);
        int k = 0;
        while (got_q.size() == 0 && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (got_q.size() == 0) check({tag, "_timeout"}, 0, 1);
        else check(tag, {24'd0, got_q.pop_front()}, {24'd0, rx_q.pop_front()});
    endtask

    int snap;

    initial begin
        bus.tx_data  = '0;
        bus.tx_valid = 1'b0;
        bus.rx_ready = 1'b0;
        cycles(4);
        check("rst_miso", {31'd0, miso}, 0);
        check("rst_tx_ready", {31'd0, bus.tx_ready}, 1);
        check("rst_rx_valid", {31'd0, bus.rx_valid}, 0);
        check("rst_rx_data", {24'd0, bus.rx_data}, 0);
        check("rst_busy", {31'd0, bus.busy}, 0);
        check("rst_pulses", {29'd0, bus.rx_overrun, bus.tx_underrun, bus.frame_err}, 0);
        rst = 1'b0;
        cycles(4);

        // T1: preloaded A5 out, 3C in
        push_tx(8'hA5);
        check("t1_tx_full", {31'd0, bus.tx_ready}, 0);
        select();
        check("t1_busy", {31'd0, bus.busy}, 1);
        xfer("t1", 8'h3C, 8'hA5, 8);
        deselect();
        check("t1_rx_valid", {31'd0, bus.rx_valid}, 1);
        check("t1_rx_data", {24'd0, bus.rx_data}, 32'h3C);
        check("t1_busy_off", {31'd0, bus.busy}, 0);
        check("t1_miso_idle", {31'd0, miso}, 0);
        rx_q.push_back(8'h3C);
        bus.rx_ready = 1'b1;
        chk_rx("t1_rx");

        // T2: back-to-back words, second TX word buffered mid-frame
        snap = n_ferr;
        push_tx(8'h81);
        select();
        push_tx(8'h42);
        rx_q.push_back(8'h01);
        rx_q.push_back(8'hFE);
        xfer("t2a", 8'h01, 8'h81, 8);
        xfer("t2b", 8'hFE, 8'h42, 8);
        deselect();
        chk_rx("t2_rx0");
        chk_rx("t2_rx1");
        check("t2_no_ferr", n_ferr - snap, 0);
        check("t2_rx_valid", {31'd0, bus.rx_valid}, 0);

        // T3: no preload, default word and underrun
        snap = n_under;
        select();
        rx_q.push_back(8'h96);
        xfer("t3", 8'h96, TXD, 8);
        check("t3_underrun_once", n_under - snap, 1);
        deselect();
        check("t3_underrun_trail", n_under - snap, 2);
        chk_rx("t3_rx");

        // T4: overrun with rx_ready low
        bus.rx_ready = 1'b0;
        snap = n_over;
        select();
        xfer("t4a", 8'h11, TXD, 8);
        xfer("t4b", 8'h22, TXD, 8);
        deselect();
        check("t4_rx_data", {24'd0, bus.rx_data}, 32'h22);
        check("t4_rx_valid", {31'd0, bus.rx_valid}, 1);
        check("t4_overrun", n_over - snap, 1);
        rx_q.push_back(8'h22);
        bus.rx_ready = 1'b1;
        chk_rx("t4_rx");
        check("t4_no_extra", got_q.size(), 0);

        // T5: abort after 5 bits
        snap = n_ferr;
        select();
        xfer("t5", 8'hF0, TXD, 5);
        deselect();
        check("t5_ferr", n_ferr - snap, 1);
        check("t5_rx_valid", {31'd0, bus.rx_valid}, 0);
        check("t5_rx_data", {24'd0, bus.rx_data}, 32'h22);
        check("t5_miso", {31'd0, miso}, 0);
        check("t5_busy", {31'd0, bus.busy}, 0);

        // T6: reset mid-word with a buffered TX word
        push_tx(8'h77);
        select();
        push_tx(8'h88);
        xfer("t6a", 8'hE0, 8'h77, 3);
        rst  = 1'b1;
        ss_n = 1'b1;
        sck  = 1'b0;
        mosi = 1'b0;
        cycles(1);
        check("t6_miso", {31'd0, miso}, 0);
        check("t6_tx_ready", {31'd0, bus.tx_ready}, 1);
        check("t6_rx_valid", {31'd0, bus.rx_valid}, 0);
        check("t6_rx_data", {24'd0, bus.rx_data}, 0);
        check("t6_busy", {31'd0, bus.busy}, 0);
        rst = 1'b0;
        cycles(5);
        push_tx(8'hC3);
        select();
        rx_q.push_back(8'h5A);
        xfer("t6b", 8'h5A, 8'hC3, 8);
        deselect();
        chk_rx("t6_rx");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
